prio_encoder_q: RTL and testbench

- Parametrised, registered successor to the 8-to-3 encoder.
- Accepts N single-cycle request strobes and latches them into a pending vector.
- Emits each pending request, one at a time, as a binary index on a valid/ready output port.
- Arbitration is fixed-priority (index 0 highest) or round-robin.
- Sits between interrupt/event sources and a single consumer, e.g. a controller FSM or a FIFO writer.

---
 rtl/prio_encoder_q.sv | 97 +++++++++
 tb/tb_prio_encoder_q.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_q.sv
// Registered priority encoder: latches request strobes into a pending vector and emits one index per grant.
// Arbitration is fixed-priority (RR_MODE=0) or round-robin (RR_MODE=1); define PRIO_ENC_OVERFLOW_EN for the sticky ovf flag.
module prio_encoder_q #(
    parameter int N       = 8,
    parameter int RR_MODE = 0,
    localparam int IDX_W  = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     pending,
`ifdef PRIO_ENC_OVERFLOW_EN
    output logic             ovf,
    input  logic             ovf_clr,
`endif
    output logic             busy
);

    logic [N-1:0]     r_pending;
    logic             r_out_valid;
    logic [IDX_W-1:0] r_out_idx;
    logic [IDX_W-1:0] r_ptr;

    logic             w_sel_found;
    logic [IDX_W-1:0] w_sel_idx;
    logic [IDX_W-1:0] w_pos;
    logic             w_load;
    logic [N-1:0]     w_grant;
    int               w_scan;

    // Search starts at r_ptr in round-robin mode, at 0 otherwise; only the registered vector is scanned.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_pos       = '0;
        w_scan      = 0;
        for (int k = 0; k < N; k++) begin
            w_scan = (RR_MODE != 0) ? ((int'(r_ptr) + k) % N) : k;
            w_pos  = w_scan[IDX_W-1:0];
            if (!w_sel_found && r_pending[w_pos]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_pos;
            end
        end
    end

    // Output handshake: a beat transfers when out_valid && out_ready at a rising edge; the slot refills whenever it is empty or being drained.
    assign w_load  = (|r_pending) && (!r_out_valid || out_ready);
    assign w_grant = w_load ? ({{(N-1){1'b0}}, 1'b1} << w_sel_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_ptr       <= '0;
        end else begin
            r_pending <= (r_pending & ~w_grant) | req;
            if (w_load) begin
                r_out_idx   <= w_sel_idx;
                r_out_valid <= 1'b1;
                r_ptr       <= (w_sel_idx == IDX_W'(N - 1)) ? '0 : w_sel_idx + 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef PRIO_ENC_OVERFLOW_EN
    logic r_ovf;
    logic w_ovf_set;

    // A request is lost when it lands on a bit that is still pending and not being granted now.
    assign w_ovf_set = |(req & r_pending & ~w_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`endif

    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign pending   = r_pending;
    assign busy      = (|r_pending) || r_out_valid;

endmodule

// File: tb/tb_prio_encoder_q.sv
// Bench for prio_encoder_q: fixed-priority and round-robin instances driven in lockstep against an array-based model.
module tb_prio_encoder_q;
    localparam int N  = 8;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          out_ready;
    logic          ovf_clr;
    logic [N-1:0]  req;
    logic          fp_valid, rr_valid, fp_busy, rr_busy;
    logic [IW-1:0] fp_idx, rr_idx;
    logic [N-1:0]  fp_pend, rr_pend;
`ifdef PRIO_ENC_OVERFLOW_EN
    logic          fp_ovf, rr_ovf;
`endif

    prio_encoder_q #(.N(N), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .req(req), .out_valid(fp_valid), .out_ready(out_ready),
        .out_idx(fp_idx), .pending(fp_pend),
`ifdef PRIO_ENC_OVERFLOW_EN
        .ovf(fp_ovf), .ovf_clr(ovf_clr),
`endif
        .busy(fp_busy)
    );

    prio_encoder_q #(.N(N), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .req(req), .out_valid(rr_valid), .out_ready(out_ready),
        .out_idx(rr_idx), .pending(rr_pend),
`ifdef PRIO_ENC_OVERFLOW_EN
        .ovf(rr_ovf), .ovf_clr(ovf_clr),
`endif
        .busy(rr_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int seq_idx[3] = '{2, 5, 7};

    // Reference model, index 0 = fixed priority, 1 = round robin
    bit m_pend[2][N];
    bit m_val[2];
    int m_idx[2];
    int m_ptr[2];
    bit m_ovf[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int m);
        bit any_p;
        bit lost;
        int g;
        if (rst) begin
            for (int k = 0; k < N; k++) m_pend[m][k] = 1'b0;
            m_val[m] = 1'b0;
            m_idx[m] = 0;
            m_ptr[m] = 0;
            m_ovf[m] = 1'b0;
            return;
        end
        any_p = 1'b0;
        for (int k = 0; k < N; k++) any_p |= m_pend[m][k];
        g = -1;
        if (any_p && (!m_val[m] || out_ready)) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m == 1) ? (m_ptr[m] + k) % N : k;
                if (g < 0 && m_pend[m][j]) g = j;
            end
        end
        lost = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (req[k] && m_pend[m][k] && k != g) lost = 1'b1;
            m_pend[m][k] = (m_pend[m][k] && k != g) || req[k];
        end
        if (g >= 0) begin
            m_idx[m] = g;
            m_val[m] = 1'b1;
            m_ptr[m] = (g + 1) % N;
        end else if (out_ready) begin
            m_val[m] = 1'b0;
        end
        if (lost) m_ovf[m] = 1'b1;
        else if (ovf_clr) m_ovf[m] = 1'b0;
    endtask

    task automatic check_dut(input int m);
        logic [N-1:0] exp_pend;
        bit any_p;
        any_p = 1'b0;
        for (int k = 0; k < N; k++) begin
            exp_pend[k] = m_pend[m][k];
            any_p |= m_pend[m][k];
        end
        check($sformatf("m%0d valid", m), (m == 1) ? rr_valid : fp_valid, m_val[m]);
        check($sformatf("m%0d idx", m), (m == 1) ? rr_idx : fp_idx, m_idx[m]);
        check($sformatf("m%0d pending", m), (m == 1) ? rr_pend : fp_pend, exp_pend);
        check($sformatf("m%0d busy", m), (m == 1) ? rr_busy : fp_busy, any_p || m_val[m]);
`ifdef PRIO_ENC_OVERFLOW_EN
        check($sformatf("m%0d ovf", m), (m == 1) ? rr_ovf : fp_ovf, m_ovf[m]);
`endif
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic rdy, input logic rs, input logic clr);
        req       = r;
        out_ready = rdy;
        rst       = rs;
        ovf_clr   = clr;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    initial begin
        req = '0; out_ready = 1'b1; rst = 1'b1; ovf_clr = 1'b0;

        // Reset state
        cyc(8'h00, 1'b1, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b1, 1'b0);
        check("rst valid", fp_valid, 1'b0);
        check("rst pending", fp_pend, 8'h00);
        check("rst idx", fp_idx, 3'd0);
        check("rst busy", rr_busy, 1'b0);

        // Three requests in one strobe drain in index order
        cyc(8'h00, 1'b1, 1'b0, 1'b0);
        cyc(8'hA4, 1'b1, 1'b0, 1'b0);
        check("seq pend", fp_pend, 8'hA4);
        check("seq latency", fp_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(8'h00, 1'b1, 1'b0, 1'b0);
            check("seq fp valid", fp_valid, 1'b1);
            check("seq fp idx", fp_idx, seq_idx[i]);
            check("seq rr idx", rr_idx, seq_idx[i]);
        end
        cyc(8'h00, 1'b1, 1'b0, 1'b0);
        check("seq end valid", fp_valid, 1'b0);
        check("seq end pend", fp_pend, 8'h00);

        // Round robin under a held all-ones request
        cyc(8'h00, 1'b1, 1'b1, 1'b0);
        cyc(8'hFF, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(8'hFF, 1'b1, 1'b0, 1'b0);
            check("rr idx", rr_idx, k % 8);
            check("fp idx held ff", fp_idx, 3'd0);
        end
        for (int k = 0; k < 10; k++) cyc(8'h00, 1'b1, 1'b0, 1'b0);
        check("rr drained", rr_busy, 1'b0);

        // Backpressure
        cyc(8'h00, 1'b1, 1'b1, 1'b0);
        cyc(8'h03, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(8'h00, 1'b0, 1'b0, 1'b0);
            check("bp valid", fp_valid, 1'b1);
            check("bp idx", fp_idx, 3'd0);
            check("bp pend", fp_pend, 8'h02);
        end
        cyc(8'h00, 1'b1, 1'b0, 1'b0);
        check("bp idx1", fp_idx, 3'd1);
        check("bp valid1", fp_valid, 1'b1);
        cyc(8'h00, 1'b1, 1'b0, 1'b0);
        check("bp drop", fp_valid, 1'b0);

        // Same-cycle set and clear of one bit
        cyc(8'h00, 1'b1, 1'b1, 1'b0);
        cyc(8'h01, 1'b1, 1'b0, 1'b0);
        cyc(8'h01, 1'b1, 1'b0, 1'b0);
        check("sc pend kept", fp_pend, 8'h01);
        check("sc idx first", fp_idx, 3'd0);
        cyc(8'h00, 1'b1, 1'b0, 1'b0);
        check("sc idx second", fp_idx, 3'd0);
        check("sc valid second", fp_valid, 1'b1);
`ifdef PRIO_ENC_OVERFLOW_EN
        check("sc no ovf", fp_ovf, 1'b0);
`endif
        cyc(8'h00, 1'b1, 1'b0, 1'b0);
        check("sc drop", fp_valid, 1'b0);

`ifdef PRIO_ENC_OVERFLOW_EN
        // Overflow, clear, and clear colliding with a new overflow
        cyc(8'h00, 1'b1, 1'b1, 1'b0);
        cyc(8'h10, 1'b0, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        cyc(8'h10, 1'b0, 1'b0, 1'b0);
        check("ovf not yet", fp_ovf, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        cyc(8'h10, 1'b0, 1'b0, 1'b0);
        check("ovf set", fp_ovf, 1'b1);
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        check("ovf clr", fp_ovf, 1'b0);
        cyc(8'h10, 1'b0, 1'b0, 1'b1);
        check("ovf set wins", fp_ovf, 1'b1);
`endif

        // Reset in the middle of activity
        cyc(8'h00, 1'b1, 1'b1, 1'b0);
        cyc(8'hF0, 1'b0, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        cyc(8'hF0, 1'b0, 1'b0, 1'b0);
        check("mid pend", fp_pend, 8'hF0);
        check("mid valid", fp_valid, 1'b1);
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
        check("mid rst pend", fp_pend, 8'h00);
        check("mid rst valid", rr_valid, 1'b0);
        check("mid rst idx", rr_idx, 3'd0);
        cyc(8'h80, 1'b1, 1'b0, 1'b0);
        cyc(8'h00, 1'b1, 1'b0, 1'b0);
        check("post rst fp idx", fp_idx, 3'd7);
        check("post rst rr idx", rr_idx, 3'd7);
        cyc(8'h00, 1'b1, 1'b0, 1'b0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] r;
            r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            cyc(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
